// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter sharing one I2C write engine between two requesters,
// with a per-transaction completion timeout.
module i2c_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic [23:0] i_data0,
    output logic        o_ack0,
    output logic        o_done0,
    output logic        o_err0,
    input  logic        i_req1,
    input  logic [23:0] i_data1,
    output logic        o_ack1,
    output logic        o_done1,
    output logic        o_err1,
    output logic        o_eng_start,
    output logic [23:0] o_eng_data,
    input  logic        i_eng_finished,
    output logic        o_busy
);
    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic        grant, last, err, pick, any_req;
    logic [15:0] cnt;

    assign any_req = i_req0 || i_req1;
    // Under contention the requester not served last wins.
    assign pick = (i_req0 && i_req1) ? ~last : i_req1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            grant      <= 1'b0;
            err        <= 1'b0;
            o_eng_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                grant      <= pick;
                o_eng_data <= pick ? i_data1 : i_data0;
            end
            if (state == ISSUE) cnt <= '0;
            // Overwritten every WAIT cycle; the value at exit reflects why WAIT ended.
            if (state == WAIT) begin
                cnt <= cnt + 16'd1;
                err <= !i_eng_finished;
            end
            if (state == DONE) last <= grant;
        end
    end

    always_comb begin
        state_n     = state;
        o_eng_start = 1'b0;
        o_ack0      = 1'b0;
        o_ack1      = 1'b0;
        o_done0     = 1'b0;
        o_done1     = 1'b0;
        o_err0      = 1'b0;
        o_err1      = 1'b0;
        o_busy      = state != IDLE;
        case (state)
            IDLE:  state_n = any_req ? ISSUE : IDLE;
            ISSUE: begin
                state_n     = WAIT;
                o_eng_start = 1'b1;
                o_ack0      = !grant;
                o_ack1      = grant;
            end
            WAIT:  state_n = (i_eng_finished || cnt == CNT_MAX) ? DONE : WAIT;
            DONE:  begin
                state_n = IDLE;
                o_done0 = !grant;
                o_done1 = grant;
                o_err0  = !grant && err;
                o_err1  = grant && err;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed bench; dut_a uses the default timeout, dut_b a 16-cycle timeout.
module tb_i2c_cmd_arbiter;
    logic        i_clk = 0, i_rst = 1, i_req0 = 0, i_req1 = 0, i_eng_finished = 0;
    logic [23:0] i_data0 = '0, i_data1 = '0;
    logic        a_ack0, a_done0, a_err0, a_ack1, a_done1, a_err1, a_start, a_busy;
    logic        b_ack0, b_done0, b_err0, b_ack1, b_done1, b_err1, b_start, b_busy;
    logic [23:0] a_data, b_data;
    int          checks = 0, failures = 0, n;
    logic [24:0] sb[$];
    logic [24:0] exp_t;
    logic        seen;
    logic [23:0] d0, d1;

    always #5 i_clk = ~i_clk;

    i2c_cmd_arbiter dut_a (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_data0(i_data0), .o_ack0(a_ack0), .o_done0(a_done0), .o_err0(a_err0),
        .i_req1(i_req1), .i_data1(i_data1), .o_ack1(a_ack1), .o_done1(a_done1), .o_err1(a_err1),
        .o_eng_start(a_start), .o_eng_data(a_data), .i_eng_finished(i_eng_finished), .o_busy(a_busy)
    );

    i2c_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_data0(i_data0), .o_ack0(b_ack0), .o_done0(b_done0), .o_err0(b_err0),
        .i_req1(i_req1), .i_data1(i_data1), .o_ack1(b_ack1), .o_done1(b_done1), .o_err1(b_err1),
        .o_eng_start(b_start), .o_eng_data(b_data), .i_eng_finished(i_eng_finished), .o_busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge i_clk);
    endtask

    task automatic wait_ack(input bit use_b, output int cnt);
        cnt = 0;
        do begin
            tick;
            cnt++;
        end while (!(use_b ? (b_ack0 || b_ack1) : (a_ack0 || a_ack1)) && cnt < 30);
    endtask

    task automatic pop_exp;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            exp_t = '0;
        end else exp_t = sb.pop_front();
    endtask

    initial begin
        // Reset state
        repeat (2) tick;
        check("rst_busy_a", a_busy, 0);
        check("rst_data_a", a_data, 0);
        check("rst_start_a", a_start, 0);
        check("rst_busy_b", b_busy, 0);

        // Single request, engine finishes 50 cycles after start
        i_rst = 0;
        i_req0 = 1; i_data0 = 24'h341E00;
        sb.push_back({1'b0, 24'h341E00});
        tick;
        check("single_start", a_start, 1);
        check("single_ack0", a_ack0, 1);
        check("single_ack1", a_ack1, 0);
        pop_exp;
        check("single_data", a_data, exp_t[23:0]);
        i_req0 = 0; i_data0 = 24'hFFFFFF;
        repeat (50) tick;
        i_eng_finished = 1;
        tick;
        i_eng_finished = 0;
        check("single_done0", a_done0, 1);
        check("single_err0", a_err0, 0);
        check("single_data_stable", a_data, 24'h341E00);
        tick;
        check("single_idle", a_busy, 0);

        // Stray finished in IDLE
        i_eng_finished = 1;
        tick;
        i_eng_finished = 0;
        check("stray_busy", a_busy, 0);
        check("stray_outs", {a_start, a_ack0, a_ack1, a_done0, a_done1, a_err0, a_err1}, 0);
        tick;
        check("stray_busy2", a_busy, 0);

        // Contention: both held from reset release, grants alternate
        d0 = 24'h1A2B3C; d1 = 24'h4D5E6F;
        i_rst = 1; i_req0 = 1; i_req1 = 1; i_data0 = d0; i_data1 = d1;
        tick;
        check("rr_rst_busy", a_busy, 0);
        check("rr_rst_ack", a_ack0 | a_ack1, 0);
        for (int i = 0; i < 4; i++) sb.push_back({i[0], i[0] ? d1 : d0});
        i_rst = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, n);
            check("rr_latency", n, i == 0 ? 1 : 2);
            check("rr_one_ack", a_ack0 & a_ack1, 0);
            pop_exp;
            check("rr_grant", a_ack1, exp_t[24]);
            check("rr_data", a_data, exp_t[23:0]);
            repeat (3) tick;
            i_eng_finished = 1;
            tick;
            i_eng_finished = 0;
            check("rr_done", {a_done1, a_done0}, exp_t[24] ? 2 : 1);
            check("rr_err", a_err0 | a_err1, 0);
        end

        // Timeout on 16-cycle instance
        i_rst = 1; i_req0 = 0; i_req1 = 1; i_data1 = 24'h3C5A01;
        sb.push_back({1'b1, 24'h3C5A01});
        tick;
        i_rst = 0;
        wait_ack(1, n);
        pop_exp;
        check("to_ack1", b_ack1, exp_t[24]);
        check("to_data", b_data, exp_t[23:0]);
        i_req1 = 0;
        n = 0;
        do begin
            tick;
            n++;
        end while (!b_done1 && n < 40);
        check("to_latency", n, 17);
        check("to_err1", b_err1, 1);
        check("to_done0", b_done0 | b_err0, 0);
        tick;
        check("to_busy_drop", b_busy, 0);
        check("to_err_pulse", b_err1, 0);

        // Finished coincides with counter = TIMEOUT-1
        i_rst = 1; i_req0 = 1; i_data0 = 24'h123456;
        tick;
        i_rst = 0;
        wait_ack(1, n);
        check("co_ack0", b_ack0, 1);
        i_req0 = 0;
        repeat (16) tick;
        check("co_still_wait", b_done0, 0);
        i_eng_finished = 1;
        tick;
        i_eng_finished = 0;
        check("co_done0", b_done0, 1);
        check("co_err0", b_err0, 0);

        // Reset mid-WAIT
        i_rst = 1; i_req1 = 1; i_data1 = 24'hABCDEF;
        tick;
        i_rst = 0;
        wait_ack(1, n);
        check("rw_ack1", b_ack1, 1);
        i_req1 = 0;
        repeat (3) tick;
        check("rw_in_wait", b_busy, 1);
        i_rst = 1;
        tick;
        i_rst = 0;
        check("rw_busy", b_busy, 0);
        check("rw_data", b_data, 0);
        seen = b_done0 | b_done1 | b_err0 | b_err1;
        repeat (20) begin
            tick;
            seen |= b_done0 | b_done1 | b_err0 | b_err1;
        end
        check("rw_no_done", seen, 0);
        i_req0 = 1; i_req1 = 1;
        wait_ack(1, n);
        check("rw_new_latency", n, 1);
        check("rw_new_grant", {b_ack1, b_ack0}, 2'b01);
        check("rw_new_data", b_data, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
